walker_job_arbiter: RTL and testbench
=====================================

Name: walker_job_arbiter

Overview:
Round-robin arbiter and job sequencer that shares one 10-state walker FSM between NREQ requesters. The walker has inputs x, rst and clk, and a terminal-state flag y.
For each granted requester the block clears the walker, drives the requester's direction bit onto the walker's x input, and counts cycles until the walker raises y. It then reports the count, or a timeout error, and releases the walker to the next requester.
It sits between requester logic and the walker instance, and owns the walker's reset and x inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; equals clog2(NREQ)
CW, 8, width of cycle counter and result
MAX_CYC, 16, RUN cycles allowed without wk_y before timeout; must be ≤ 2^CW-1

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester job request, level
dir  in  NREQ  per-requester direction bit, driven to wk_x for that requester's job
gnt  out  NREQ  one-hot grant, held for the whole job
busy  out  1  high when the state is not IDLE
done  out  1  one-cycle pulse at job end
done_id  out  IDW  index of the finished requester, valid with done
result  out  CW  RUN cycles counted before wk_y, valid with done
err  out  1  timeout flag, valid with done
wk_rst  out  1  walker reset
wk_x  out  1  walker x input
wk_y  in  1  walker terminal flag

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE; gnt=0, busy=0, done=0, done_id=0, result=0, err=0, wk_x=0; rr pointer last=NREQ-1, so req[0] has highest priority first.
- wk_rst = rst OR (state==CLR). The walker is therefore held in reset during block reset.
- States: IDLE, CLR, RUN, DONE.
- IDLE: if req≠0, pick the first asserted index scanning last+1, last+2, … mod NREQ. Latch it as cur; latch dir[cur] as curdir; set gnt=onehot(cur); go to CLR. Otherwise stay in IDLE.
- CLR: one cycle, wk_rst=1; cnt←0; go to RUN.
- RUN: wk_x=curdir, wk_rst=0. Each cycle:
  - if wk_y=1: result←cnt, err←0, go to DONE;
  - else if cnt==MAX_CYC-1: result←MAX_CYC, err←1, go to DONE;
  - else cnt←cnt+1.
- DONE: done=1 for exactly one cycle, with done_id=cur; last←cur; gnt←0; go to IDLE. result and err hold until the next DONE.
- Job latency with wk_y asserted on RUN cycle k (0-based): the grant-to-done pulse spans 1 (CLR) + k+1 (RUN) cycles, then done is high for 1 cycle. The next grant is evaluated the cycle after DONE (IDLE), so there is one idle cycle minimum between jobs.
- req or dir changing after grant: ignored until the job ends. The job always completes; there is no abort.
- wk_y high on the first RUN cycle: result=0.
- Simultaneous requests: strict round-robin. A requester holding req continuously cannot win twice in a row while another request is pending.
- rst mid-job: immediate return to IDLE with all outputs at reset values; the walker is reset; no done pulse.
- wk_x is 0 in every state except RUN.

Test Plan:
1. Conforming walker; only req[2]=1 with dir[2]=0 → gnt=4'b0100; one wk_rst cycle; done with done_id=2, result=9, err=0.
2. Conforming walker; req[1]=1 with dir[1]=1 → done_id=1, result=1, err=0; the done pulse lands 3 cycles after CLR.
3. req=4'b1111 held for 8 jobs → grant order 0,1,2,3,0,1,2,3; one IDLE cycle between each DONE and the next CLR.
4. wk_y tied to 0, req[0]=1 → after exactly 16 RUN cycles: done, result=16, err=1, gnt returns to 0.
5. rst asserted on the 3rd RUN cycle → next cycle: busy=0, gnt=0, wk_rst=1, no done; after rst falls with req[3]=1, the grant goes to 3 and the job runs normally.
6. req[0] deasserted and dir[0] toggled mid-RUN → wk_x stays at the latched value; the job completes with result=9 (dir latched as 0).

Source files
------------

// File: rtl/walker_job_arbiter.sv
// Round-robin arbiter that shares one walker FSM between NREQ requesters:
// it clears the walker, drives the winner's direction bit and times the walk to wk_y.
module walker_job_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned CW      = 8,
  parameter int unsigned MAX_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] dir,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic [CW-1:0]   result,
  output logic            err,
  output logic            wk_rst,
  output logic            wk_x,
  input  logic            wk_y
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] cur;
  logic           curdir;
  logic [CW-1:0]  cnt;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;

  // Scan last+NREQ down to last+1 so the closest index after last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      cand = IDW'((32'(last) + i) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // The walker is held in reset for block reset and for the one CLR cycle.
  assign wk_rst = rst | (state == CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
      err     <= 1'b0;
      wk_x    <= 1'b0;
      last    <= IDW'(NREQ - 1);
      cur     <= '0;
      curdir  <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cur    <= pick_idx;
            curdir <= dir[pick_idx];
            gnt    <= NREQ'(1) << pick_idx;
            busy   <= 1'b1;
            state  <= CLR;
          end
        end
        CLR: begin
          cnt   <= '0;
          wk_x  <= curdir;
          state <= RUN;
        end
        RUN: begin
          if (wk_y) begin
            result  <= cnt;
            err     <= 1'b0;
            wk_x    <= 1'b0;
            done    <= 1'b1;
            done_id <= cur;
            state   <= DONE;
          end else if (cnt == CW'(MAX_CYC - 1)) begin
            // Walker never reached its terminal state within the budget.
            result  <= CW'(MAX_CYC);
            err     <= 1'b1;
            wk_x    <= 1'b0;
            done    <= 1'b1;
            done_id <= cur;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          last  <= cur;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_walker_job_arbiter.sv
// Self-checking bench for walker_job_arbiter with a 10-state ring walker model:
// x=0 steps forward, x=1 steps backward, y is high in state 9.
module tb_walker_job_arbiter;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int CW      = 8;
  localparam int MAX_CYC = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] dir = '0;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic [CW-1:0]   result;
  logic            err;
  logic            wk_rst;
  logic            wk_x;
  logic            wk_y;

  bit stuck = 1'b0;
  int wst   = 0;
  int checks = 0;
  int errors = 0;
  int m_last = NREQ - 1;

  always #5 clk = ~clk;

  walker_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .CW(CW), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .result(result), .err(err),
    .wk_rst(wk_rst), .wk_x(wk_x), .wk_y(wk_y)
  );

  // Conforming walker: a ring of 10 states with terminal state 9.
  always @(posedge clk) begin
    if (wk_rst) wst <= 0;
    else if (wk_x) wst <= (wst == 0) ? 9 : wst - 1;
    else wst <= (wst == 9) ? 0 : wst + 1;
  end
  assign wk_y = stuck ? 1'b0 : (wst == 9);

  // Rotating-priority winner: first requester after the last one served.
  function automatic int pick(input int last, input logic [NREQ-1:0] r);
    int q[$];
    for (int k = 1; k <= NREQ; k++) q.push_back((last + k) % NREQ);
    foreach (q[n]) if (r[q[n]]) return q[n];
    return -1;
  endfunction

  // Walk length from state 0 to 9: one step backwards, nine forwards.
  function automatic int walk_len(input bit d);
    return d ? 1 : 9;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, busy, done, done_id, result, err, wk_x} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b busy=%b done=%b id=%0d res=%0d err=%b x=%b exp all 0",
               gnt, busy, done, done_id, result, err, wk_x);
    end
    checks++;
    if (wk_rst !== 1'b1) begin errors++; $display("FAIL reset_wk_rst got %b exp 1", wk_rst); end
    rst = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk);
    checks++;
    if (wk_rst !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got wk_rst=%b busy=%b exp 0 0", wk_rst, busy);
    end
  endtask

  task automatic test_single_job(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dv);
    int w, cyc, exp_res;
    bit got, exp_dir, xbad;
    logic [NREQ-1:0] exp_g;
    @(negedge clk);
    req = rq; dir = dv;
    w = pick(m_last, rq);
    exp_dir = dv[w];
    exp_res = walk_len(exp_dir);
    exp_g = NREQ'(1) << w;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL job_grant_timeout req=%b no grant", rq); req = '0; return; end
    checks++;
    if (gnt !== exp_g) begin errors++; $display("FAIL job_gnt req=%b got %b exp %b", rq, gnt, exp_g); end
    checks++;
    if (busy !== 1'b1 || wk_rst !== 1'b1 || wk_x !== 1'b0) begin
      errors++; $display("FAIL job_clr got busy=%b wk_rst=%b wk_x=%b exp 1 1 0", busy, wk_rst, wk_x);
    end
    cyc = 0; got = 1'b0; xbad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1'b1; break; end
      if (wk_x !== exp_dir || wk_rst !== 1'b0) xbad = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL job_done_timeout req=%b no done", rq); req = '0; return; end
    checks++;
    if (xbad) begin errors++; $display("FAIL job_run_drive wk_x/wk_rst wrong during RUN exp x=%b", exp_dir); end
    checks++;
    if (cyc != exp_res + 2) begin errors++; $display("FAIL job_latency got %0d exp %0d", cyc, exp_res + 2); end
    checks++;
    if (done_id !== IDW'(w) || result !== CW'(exp_res) || err !== 1'b0 || gnt !== exp_g) begin
      errors++;
      $display("FAIL job_report got id=%0d res=%0d err=%b gnt=%b exp id=%0d res=%0d err=0 gnt=%b",
               done_id, result, err, gnt, w, exp_res, exp_g);
    end
    m_last = w;
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || gnt !== '0 || busy !== 1'b0 || result !== CW'(exp_res)) begin
      errors++;
      $display("FAIL job_release got done=%b gnt=%b busy=%b res=%0d exp 0 0 0 %0d", done, gnt, busy, result, exp_res);
    end
  endtask

  task automatic test_round_robin();
    int w, waited, exp_res;
    bit got;
    logic [NREQ-1:0] dv;
    dv = NREQ'($urandom);
    @(negedge clk);
    req = '1; dir = dv;
    for (int j = 0; j < 8; j++) begin
      w = pick(m_last, req);
      exp_res = walk_len(dv[w]);
      got = 1'b0; waited = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (gnt !== '0) begin got = 1'b1; break; end
        waited++;
      end
      checks++;
      if (!got || gnt !== NREQ'(1) << w) begin
        errors++; $display("FAIL rr_grant job %0d got %b exp %b", j, gnt, NREQ'(1) << w);
      end
      if (j > 0) begin
        checks++;
        if (waited != 0) begin errors++; $display("FAIL rr_gap job %0d extra idle cycles got %0d exp 0", j, waited); end
      end
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got || done_id !== IDW'(w) || result !== CW'(exp_res) || err !== 1'b0) begin
        errors++; $display("FAIL rr_done job %0d got id=%0d res=%0d err=%b exp id=%0d res=%0d err=0",
                           j, done_id, result, err, w, exp_res);
      end
      m_last = w;
      if (j == 7) req = '0;
      @(negedge clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL rr_idle job %0d got gnt=%b busy=%b exp 0 0", j, gnt, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int w, cyc;
    bit got;
    stuck = 1'b1;
    @(negedge clk);
    req = 4'b0001; dir = NREQ'($urandom);
    w = pick(m_last, req);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || gnt !== 4'b0001) begin errors++; $display("FAIL to_grant got %b exp 0001", gnt); end
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || cyc != MAX_CYC + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", cyc, MAX_CYC + 1); end
    checks++;
    if (result !== CW'(MAX_CYC) || err !== 1'b1 || done_id !== IDW'(w)) begin
      errors++; $display("FAIL to_report got res=%0d err=%b id=%0d exp res=%0d err=1 id=%0d",
                         result, err, done_id, MAX_CYC, w);
    end
    m_last = w;
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || err !== 1'b1) begin errors++; $display("FAIL to_release got gnt=%b err=%b exp 0 1", gnt, err); end
    stuck = 1'b0;
  endtask

  task automatic test_mid_job_change();
    int cyc;
    bit got, xbad;
    @(negedge clk);
    req = 4'b0001; dir = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || gnt !== 4'b0001) begin errors++; $display("FAIL chg_grant got %b exp 0001", gnt); end
    cyc = 0; got = 1'b0; xbad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1'b1; break; end
      if (wk_x !== 1'b0) xbad = 1'b1;
      if (cyc == 2) req = '0;
      dir[0] = ~dir[0];
    end
    checks++;
    if (xbad) begin errors++; $display("FAIL chg_wk_x followed live dir exp latched 0"); end
    checks++;
    if (!got || result !== CW'(9) || err !== 1'b0 || done_id !== IDW'(0) || cyc != 11) begin
      errors++; $display("FAIL chg_report got res=%0d err=%b id=%0d cyc=%0d exp res=9 err=0 id=0 cyc=11",
                         result, err, done_id, cyc);
    end
    m_last = 0;
    req = '0; dir = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    bit got;
    @(negedge clk);
    req = 4'b0001; dir = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rmj_grant no grant before reset"); end
    repeat (3) @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0 || wk_rst !== 1'b1 || done !== 1'b0 ||
        result !== '0 || err !== 1'b0 || wk_x !== 1'b0) begin
      errors++; $display("FAIL rmj_reset got busy=%b gnt=%b wk_rst=%b done=%b res=%0d err=%b x=%b exp 0 0 1 0 0 0 0",
                         busy, gnt, wk_rst, done, result, err, wk_x);
    end
    rst = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmj_no_done got done=%b busy=%b exp 0 0", done, busy); end
    test_single_job(4'b1000, NREQ'($urandom));
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++)
      test_single_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), NREQ'($urandom));
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_job(4'b0100, 4'b0000);
    test_single_job(4'b0010, 4'b0010);
    test_timeout();
    test_mid_job_change();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
